// File: rtl/writeback_queue_if.sv
// Write-back request channel into the queue plus the register-file write port it drives.
// The queue takes the slave view; the datapath/register-file side takes the master view.
interface writeback_queue_if;
   logic        InValid;
   logic [4:0]  InAddr;
   logic [31:0] InData;
   logic        InReady;
   logic        Stall;
   logic        RegWrite;
   logic [4:0]  WriteAddr;
   logic [31:0] WriteData;

   modport master (
      output InValid, InAddr, InData, Stall,
      input  InReady, RegWrite, WriteAddr, WriteData
   );

   modport slave (
      input  InValid, InAddr, InData, Stall,
      output InReady, RegWrite, WriteAddr, WriteData
   );
endinterface

// File: rtl/writeback_queue.sv
// Circular write-back buffer feeding the single register-file write port, with a
// two-port youngest-match lookup that stands in for the missing register-file bypass.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   writeback_queue_if.slave           wb,
   input  logic [4:0]                 LookupAddr1,
   input  logic [4:0]                 LookupAddr2,
   output logic                       Hit1,
   output logic                       Hit2,
   output logic [31:0]                HitData1,
   output logic [31:0]                HitData2,
   output logic [$clog2(DEPTH):0]     Count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } lookup_t;

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [AW:0]   count_q;
   logic          push, enq, drain;
   lookup_t       lk1, lk2;

   assign drain        = (count_q != '0) && !wb.Stall;
   assign wb.RegWrite  = drain;
   assign wb.InReady   = (count_q != FULL) || drain;
   assign wb.WriteAddr = (count_q != '0) ? addr_q[head_q] : '0;
   assign wb.WriteData = (count_q != '0) ? data_q[head_q] : '0;
   assign Count        = count_q;

   // $zero writes complete the handshake but are never stored
   assign push = wb.InValid && wb.InReady;
   assign enq  = push && (wb.InAddr != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq)   tail_q <= tail_q + 1'b1;
         if (drain) head_q <= head_q + 1'b1;
         case ({enq, drain})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload needs no reset: occupancy gates every read of it.
   always_ff @(posedge clock) begin
      if (enq) begin
         addr_q[tail_q] <= wb.InAddr;
         data_q[tail_q] <= wb.InData;
      end
   end

   // Walk oldest to youngest so the last match (nearest tail) wins.
   function automatic lookup_t lookup(input logic [4:0] a);
      lookup_t       r;
      logic [AW-1:0] idx;
      r   = '0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if (((AW+1)'(i) < count_q) && (a != '0) && (addr_q[idx] == a)) begin
            r.hit  = 1'b1;
            r.data = data_q[idx];
         end
      end
      return r;
   endfunction

   always_comb begin
      lk1 = lookup(LookupAddr1);
      lk2 = lookup(LookupAddr2);
   end

   assign Hit1     = lk1.hit;
   assign HitData1 = lk1.data;
   assign Hit2     = lk2.hit;
   assign HitData2 = lk2.data;
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, latency, stall/youngest-hit, full streaming,
// $zero filtering, simultaneous push/drain at Count=1, and reset discarding pending writes.
module tb_writeback_queue;
   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  LookupAddr1, LookupAddr2;
   logic        Hit1, Hit2;
   logic [31:0] HitData1, HitData2;
   logic [2:0]  Count;
   int          n_chk = 0;
   int          n_fail = 0;

   writeback_queue_if wb();

   writeback_queue #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .wb          (wb),
      .LookupAddr1 (LookupAddr1),
      .LookupAddr2 (LookupAddr2),
      .Hit1        (Hit1),
      .Hit2        (Hit2),
      .HitData1    (HitData1),
      .HitData2    (HitData2),
      .Count       (Count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d);
      wb.InValid = 1'b1;
      wb.InAddr  = a;
      wb.InData  = d;
      step();
      wb.InValid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wb.InValid = 1'b0; wb.InAddr = '0; wb.InData = '0; wb.Stall = 1'b0;
      LookupAddr1 = '0; LookupAddr2 = '0;
      step(); step();
      reset = 1'b0;
      LookupAddr1 = 5'd5;
      #1;
      chk("rst_count", Count, 0);
      chk("rst_regwrite", wb.RegWrite, 0);
      chk("rst_inready", wb.InReady, 1);
      chk("rst_waddr", wb.WriteAddr, 0);
      chk("rst_wdata", wb.WriteData, 0);
      chk("rst_hit1", Hit1, 0);
      chk("rst_hitdata1", HitData1, 0);

      // single push: not bypassed in its own cycle, visible and written the next
      wb.InValid = 1'b1; wb.InAddr = 5'd8; wb.InData = 32'hDEADBEEF;
      LookupAddr1 = 5'd8;
      #1;
      chk("nobypass_hit1", Hit1, 0);
      step();
      wb.InValid = 1'b0;
      #1;
      chk("single_regwrite", wb.RegWrite, 1);
      chk("single_waddr", wb.WriteAddr, 8);
      chk("single_wdata", wb.WriteData, 32'hDEADBEEF);
      chk("single_hit1", Hit1, 1);
      chk("single_hitdata1", HitData1, 32'hDEADBEEF);
      step();
      chk("single_after_regwrite", wb.RegWrite, 0);
      chk("single_after_count", Count, 0);
      chk("single_after_hit1", Hit1, 0);

      // stalled fill, youngest match, rejected push when full
      wb.Stall = 1'b1;
      push(5'd1, 32'd1); push(5'd2, 32'd2); push(5'd1, 32'd3); push(5'd3, 32'd4);
      #1;
      chk("stall_count", Count, 4);
      chk("stall_inready", wb.InReady, 0);
      chk("stall_regwrite", wb.RegWrite, 0);
      wb.InValid = 1'b1; wb.InAddr = 5'd9; wb.InData = 32'd99;
      step();
      wb.InValid = 1'b0;
      LookupAddr1 = 5'd9; LookupAddr2 = 5'd1;
      #1;
      chk("full_reject_count", Count, 4);
      chk("full_reject_hit1", Hit1, 0);
      chk("youngest_hit2", Hit2, 1);
      chk("youngest_hitdata2", HitData2, 3);
      LookupAddr1 = 5'd3;
      #1;
      chk("lookup_r3", HitData1, 4);
      wb.Stall = 1'b0;
      #1;
      chk("drain0_rw", wb.RegWrite, 1);
      chk("drain0_addr", wb.WriteAddr, 1);
      chk("drain0_data", wb.WriteData, 1);
      step();
      chk("drain1_addr", wb.WriteAddr, 2);
      chk("drain1_data", wb.WriteData, 2);
      chk("drain1_rw", wb.RegWrite, 1);
      step();
      chk("drain2_addr", wb.WriteAddr, 1);
      chk("drain2_data", wb.WriteData, 3);
      step();
      chk("drain3_addr", wb.WriteAddr, 3);
      chk("drain3_data", wb.WriteData, 4);
      chk("drain3_hit2", Hit2, 0);
      step();
      chk("drain_done_rw", wb.RegWrite, 0);
      chk("drain_done_count", Count, 0);

      // full queue streaming: one in, one out per cycle, pointers wrap twice
      wb.Stall = 1'b1;
      for (int k = 0; k < 4; k++) push(5'(10 + k), 32'(100 + k));
      wb.Stall = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wb.InValid = 1'b1; wb.InAddr = 5'(14 + k); wb.InData = 32'(104 + k);
         #1;
         chk("stream_inready", wb.InReady, 1);
         chk("stream_count", Count, 4);
         chk("stream_rw", wb.RegWrite, 1);
         chk("stream_addr", wb.WriteAddr, 32'(10 + k));
         chk("stream_data", wb.WriteData, 32'(100 + k));
         step();
      end
      wb.InValid = 1'b0;
      for (int k = 8; k < 12; k++) begin
         #1;
         chk("tail_rw", wb.RegWrite, 1);
         chk("tail_addr", wb.WriteAddr, 32'(10 + k));
         chk("tail_data", wb.WriteData, 32'(100 + k));
         step();
      end
      chk("stream_end_count", Count, 0);

      // $zero filter
      wb.Stall = 1'b1;
      push(5'd7, 32'd77);
      wb.InValid = 1'b1; wb.InAddr = 5'd0; wb.InData = 32'h1234;
      #1;
      chk("zero_inready", wb.InReady, 1);
      step();
      wb.InValid = 1'b0;
      LookupAddr1 = 5'd0; LookupAddr2 = 5'd7;
      #1;
      chk("zero_count", Count, 1);
      chk("zero_hit1", Hit1, 0);
      chk("zero_hitdata1", HitData1, 0);
      chk("zero_hit2_r7", HitData2, 77);
      wb.Stall = 1'b0;
      #1;
      chk("zero_drain_addr", wb.WriteAddr, 7);
      step();
      chk("zero_no_write", wb.RegWrite, 0);
      chk("zero_final_count", Count, 0);

      // simultaneous push and drain at Count=1
      push(5'd5, 32'd55);
      wb.InValid = 1'b1; wb.InAddr = 5'd6; wb.InData = 32'd66;
      #1;
      chk("c1_rw", wb.RegWrite, 1);
      chk("c1_addr", wb.WriteAddr, 5);
      step();
      wb.InValid = 1'b0;
      chk("c1_count", Count, 1);
      chk("c1_next_addr", wb.WriteAddr, 6);
      chk("c1_next_data", wb.WriteData, 66);
      step();
      chk("c1_empty", Count, 0);

      // reset with pending entries and a request in flight
      wb.Stall = 1'b1;
      push(5'd1, 32'd11); push(5'd2, 32'd22); push(5'd3, 32'd33);
      wb.InValid = 1'b1; wb.InAddr = 5'd4; wb.InData = 32'd44;
      wb.Stall = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; wb.InValid = 1'b0;
      LookupAddr1 = 5'd1; LookupAddr2 = 5'd4;
      #1;
      chk("rst2_count", Count, 0);
      chk("rst2_rw", wb.RegWrite, 0);
      chk("rst2_waddr", wb.WriteAddr, 0);
      chk("rst2_hit1", Hit1, 0);
      chk("rst2_hit2", Hit2, 0);
      chk("rst2_inready", wb.InReady, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst2_no_write", wb.RegWrite, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
